mp_add_sequencer: RTL
=====================

Name: mp_add_sequencer

Overview:
Word-serial multi-precision add sequencer that sits directly upstream of the 32-bit adder and consumes its sum/carry.
- Latches two NWORDS×WIDTH operands through a valid/ready handshake.
- Feeds the combinational adder one word per cycle, LSW first, chaining the adder's carry-out through a carry register.
- Collects sum words into a result register and presents result plus final carry through a second valid/ready handshake.

Parameters:
WIDTH, 32, adder word width; must equal the attached adder width.
NWORDS, 4, words per operand (default 128-bit); legal range 1..64.

Ports:
clk_i  input  1  clock, rising edge.
rst_i  input  1  reset, asynchronous, active-high.
op_a_i  input  NWORDS*WIDTH  operand A, word 0 = LSW.
op_b_i  input  NWORDS*WIDTH  operand B.
cin_i  input  1  carry-in to word 0.
start_valid_i  input  1  operands valid.
start_ready_o  output  1  sequencer can accept operands.
add_a_o  output  WIDTH  to adder a_i.
add_b_o  output  WIDTH  to adder b_i.
add_cin_o  output  1  to adder cin_i.
add_sum_i  input  WIDTH  from adder sum_o; combinational path, same cycle.
add_cout_i  input  1  from adder cout_o.
result_o  output  NWORDS*WIDTH  full sum.
cout_o  output  1  final carry out of MSW.
done_valid_o  output  1  result valid.
done_ready_i  input  1  consumer accepts result.
busy_o  output  1  high in RUN.

Behaviour:
- Reset (async assert, all flops): state=IDLE, idx=0, carry_q=0, operand regs=0, result_o=0, cout_o=0, done_valid_o=0, busy_o=0, add_*_o=0.
- start_ready_o=1 in IDLE, 0 in RUN and DONE.
- States:
  - IDLE: on start_valid_i && start_ready_o, latch op_a_i, op_b_i, cin_i; set idx=0; go RUN. Inputs are ignored at all other times.
  - RUN: drive add_a_o=a_q[idx], add_b_o=b_q[idx], add_cin_o=(idx==0)?cin_q:carry_q. At the clock edge, write result word[idx]<=add_sum_i and carry_q<=add_cout_i.
    - If idx==NWORDS-1: cout_o<=add_cout_i, go DONE.
    - Else idx<=idx+1.
  - DONE: done_valid_o=1. result_o and cout_o hold stable until done_ready_i is sampled high, then go IDLE and clear done_valid_o. result_o keeps its last value in IDLE.
- add_a_o, add_b_o and add_cin_o are 0 outside RUN.
- Latency: accept at edge k → RUN during cycles k+1..k+NWORDS → done_valid_o high from cycle k+NWORDS+1. A same-cycle done_ready_i retires in one DONE cycle.
- No start accept in the retire cycle; minimum interval between accepts is NWORDS+2 cycles.
- Counter width is max(1,$clog2(NWORDS)). With NWORDS=1, RUN lasts exactly one cycle. idx never exceeds NWORDS-1.
- Reset mid-RUN or mid-DONE aborts immediately, with no partial result retained. start_ready_o=1 in the first cycle after rst_i deasserts.
- Assertions:
  - done_valid_o && !done_ready_i ⇒ result_o and cout_o stable next cycle.
  - start_ready_o and done_valid_o are never both high.

Optional Feature:
MP_ADD_SUB_EN
- Defined:
  - Adds port sub_i (input, 1), latched with the operands.
  - When sub_q=1, add_b_o = ~b_q[idx] and the word-0 carry-in is forced to 1, ignoring cin_i. This computes A−B.
  - cout_o=1 means no borrow.
- Undefined: no sub_i port; pure addition as above.

Test Plan:
- WIDTH=32, NWORDS=4: A=2^128−1, B=1, cin=0 → result_o=0, cout_o=1, done_valid_o exactly 5 cycles after accept.
- A=0x0000_0000_FFFF_FFFF (word 0 all ones, other words 0), B=1 → result_o=0x1_0000_0000, cout_o=0; checks carry chaining word0→word1.
- A=B=0, cin=1 → result_o=1, cout_o=0; add_cin_o=1 only in the idx=0 RUN cycle.
- Backpressure: hold done_ready_i=0 for 10 cycles while start_valid_i=1 with new operands → done_valid_o stays 1, result_o stable, start_ready_o=0, new operands not latched. Release → IDLE, then next operands accepted.
- Assert rst_i after the second RUN cycle → all outputs 0 asynchronously; after release start_ready_o=1 and a fresh add 3+4 gives result 7.
- With MP_ADD_SUB_EN: A=5, B=7, sub_i=1 → result_o=2^128−2, cout_o=0. Then A=7, B=5, sub_i=1 → result_o=2, cout_o=1.

Source files
------------

// File: rtl/mp_add_if.sv
// Bundle of signals between the multi-precision add sequencer, its operand
// producer / result consumer, and the external word adder. The slave modport
// is the sequencer's view; master is the environment's view.
// When MP_ADD_SUB_EN is defined, the bundle also carries sub_i.
interface mp_add_if #(
  parameter int WIDTH  = 32,
  parameter int NWORDS = 4
);
  logic [NWORDS*WIDTH-1:0] op_a_i;
  logic [NWORDS*WIDTH-1:0] op_b_i;
  logic                    cin_i;
  logic                    start_valid_i;
  logic                    start_ready_o;
  logic [WIDTH-1:0]        add_a_o;
  logic [WIDTH-1:0]        add_b_o;
  logic                    add_cin_o;
  logic [WIDTH-1:0]        add_sum_i;
  logic                    add_cout_i;
  logic [NWORDS*WIDTH-1:0] result_o;
  logic                    cout_o;
  logic                    done_valid_o;
  logic                    done_ready_i;
  logic                    busy_o;
`ifdef MP_ADD_SUB_EN
  logic                    sub_i;
`endif

  modport slave (
`ifdef MP_ADD_SUB_EN
    input  sub_i,
`endif
    input  op_a_i, op_b_i, cin_i, start_valid_i, add_sum_i, add_cout_i, done_ready_i,
    output start_ready_o, add_a_o, add_b_o, add_cin_o, result_o, cout_o, done_valid_o, busy_o
  );

  modport master (
`ifdef MP_ADD_SUB_EN
    output sub_i,
`endif
    output op_a_i, op_b_i, cin_i, start_valid_i, add_sum_i, add_cout_i, done_ready_i,
    input  start_ready_o, add_a_o, add_b_o, add_cin_o, result_o, cout_o, done_valid_o, busy_o
  );
endinterface

// File: rtl/mp_add_sequencer.sv
// Word-serial multi-precision add sequencer. Latches two NWORDS x WIDTH
// operands, feeds the external combinational adder one word per cycle (LSW
// first) with the carry chained through carry_q, and returns the full sum and
// final carry through a valid/ready handshake.
// Optional feature macro: MP_ADD_SUB_EN (adds sub_i; computes A-B when set).
module mp_add_sequencer #(
  parameter int WIDTH  = 32,
  parameter int NWORDS = 4
) (
  input logic      clk_i,
  input logic      rst_i,
  mp_add_if.slave  bus
);
  localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

  logic [1:0]                         state_q, state_d;
  logic [IW-1:0]                      idx_q, idx_d;
  logic                               carry_q, carry_d;
  logic                               cin_q, cin_d;
  logic [NWORDS-1:0][WIDTH-1:0]       a_q, a_d;
  logic [NWORDS-1:0][WIDTH-1:0]       b_q, b_d;
  logic [NWORDS-1:0][WIDTH-1:0]       result_q, result_d;
  logic                               cout_q, cout_d;
`ifdef MP_ADD_SUB_EN
  logic                               sub_q, sub_d;
`endif

  logic [WIDTH-1:0] b_word;
  logic             cin_word0;

  // Next-state logic: operand capture in IDLE, word stepping in RUN, retire in DONE
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    cin_d    = cin_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
`ifdef MP_ADD_SUB_EN
    sub_d    = sub_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start_valid_i) begin
          a_d     = bus.op_a_i;
          b_d     = bus.op_b_i;
          cin_d   = bus.cin_i;
`ifdef MP_ADD_SUB_EN
          sub_d   = bus.sub_i;
`endif
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        result_d[idx_q] = bus.add_sum_i;
        carry_d         = bus.add_cout_i;
        if (idx_q == LAST_IDX) begin
          cout_d  = bus.add_cout_i;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_DONE: begin
        if (bus.done_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial result
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      cin_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
`ifdef MP_ADD_SUB_EN
      sub_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      cin_q    <= cin_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
`ifdef MP_ADD_SUB_EN
      sub_q    <= sub_d;
`endif
    end
  end

  // Adder operand selection; subtraction inverts B and forces the word-0 carry
  always_comb begin
`ifdef MP_ADD_SUB_EN
    b_word    = sub_q ? ~b_q[idx_q] : b_q[idx_q];
    cin_word0 = sub_q ? 1'b1 : cin_q;
`else
    b_word    = b_q[idx_q];
    cin_word0 = cin_q;
`endif
    bus.add_a_o   = '0;
    bus.add_b_o   = '0;
    bus.add_cin_o = 1'b0;
    if (state_q == S_RUN) begin
      bus.add_a_o   = a_q[idx_q];
      bus.add_b_o   = b_word;
      bus.add_cin_o = (idx_q == '0) ? cin_word0 : carry_q;
    end
  end

  assign bus.start_ready_o = (state_q == S_IDLE);
  assign bus.busy_o        = (state_q == S_RUN);
  assign bus.done_valid_o  = (state_q == S_DONE);
  assign bus.result_o      = result_q;
  assign bus.cout_o        = cout_q;

`ifndef SYNTHESIS
  a_result_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (bus.done_valid_o && !bus.done_ready_i) |=> ($stable(bus.result_o) && $stable(bus.cout_o)));

  a_ready_done_excl: assert property (@(posedge clk_i) disable iff (rst_i)
    !(bus.start_ready_o && bus.done_valid_o));
`endif
endmodule
